// File: rtl/mandel_pkg.sv
// Shared sizes, slot-state encoding and per-pixel tag bundle for the depth scheduler.
package mandel_pkg;

    localparam int unsigned X_SIZE  = 640;
    localparam int unsigned Y_SIZE  = 480;
    localparam int unsigned DEPTH_W = 10;
    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } slot_state_e;

    // Position tags captured at dispatch and replayed with the result
    typedef struct packed {
        logic sof;
        logic eol;
        logic last;
    } pix_tag_t;

endpackage

// File: rtl/pixel_scheduler_if.sv
// Engine start/done bus plus the result stream towards the packer.
interface pixel_scheduler_if #(
    parameter int unsigned N_ENG   = 4,
    parameter int unsigned DEPTH_W = mandel_pkg::DEPTH_W
);
    import mandel_pkg::*;

    logic [N_ENG-1:0]         eng_start;
    logic [X_W-1:0]           eng_x;
    logic [Y_W-1:0]           eng_y;
    logic [N_ENG-1:0]         eng_done;
    logic [N_ENG*DEPTH_W-1:0] eng_depth;
    logic                     out_valid;
    logic                     out_ready;
    logic [DEPTH_W-1:0]       out_depth;
    logic                     out_sof;
    logic                     out_eol;

    modport master (
        output eng_start, eng_x, eng_y, out_valid, out_depth, out_sof, out_eol,
        input  eng_done, eng_depth, out_ready
    );

    modport slave (
        input  eng_start, eng_x, eng_y, out_valid, out_depth, out_sof, out_eol,
        output eng_done, eng_depth, out_ready
    );

endinterface

// File: rtl/pixel_scheduler_raster_counter.sv
// Raster position counter: x runs fastest, whole frame wraps back to (0,0).
module raster_counter #(
    parameter int unsigned X_SIZE = mandel_pkg::X_SIZE,
    parameter int unsigned Y_SIZE = mandel_pkg::Y_SIZE
) (
    input  logic                     out_stream_aclk,
    input  logic                     reset,
    input  logic                     advance,
    output logic [mandel_pkg::X_W-1:0] x,
    output logic [mandel_pkg::Y_W-1:0] y,
    output logic                     sof,
    output logic                     eol,
    output logic                     wrap
);
    import mandel_pkg::*;

    always_ff @(posedge out_stream_aclk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= wrap ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

    assign sof  = (x == '0) && (y == '0);
    assign eol  = (x == X_W'(X_SIZE - 1));
    assign wrap = eol && (y == Y_W'(Y_SIZE - 1));

endmodule

// File: rtl/pixel_scheduler.sv
// Round-robin pixel dispatcher over N_ENG depth engines with in-order result retirement.
module pixel_scheduler #(
    parameter int unsigned N_ENG   = 4,
    parameter int unsigned X_SIZE  = mandel_pkg::X_SIZE,
    parameter int unsigned Y_SIZE  = mandel_pkg::Y_SIZE,
    parameter int unsigned DEPTH_W = mandel_pkg::DEPTH_W
) (
    input  logic              out_stream_aclk,
    input  logic              reset,
    input  logic              enable,
    pixel_scheduler_if.master bus,
    output logic              frame_done,
    output logic              busy
);
    import mandel_pkg::*;

    localparam int unsigned PTR_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;

    slot_state_e        slot_q  [N_ENG];
    slot_state_e        slot_d  [N_ENG];
    logic [DEPTH_W-1:0] depth_q [N_ENG];
    logic [DEPTH_W-1:0] depth_d [N_ENG];
    pix_tag_t           tag_q   [N_ENG];
    pix_tag_t           tag_d   [N_ENG];

    logic [PTR_W-1:0] dp_q, dp_d, rp_q, rp_d;
    logic [N_ENG-1:0] start_q, start_d;
    logic [X_W-1:0]   ex_q;
    logic [Y_W-1:0]   ey_q;
    logic             valid_c, dispatch_c, retire_c;

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           r_sof, r_eol, r_wrap;

    raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_raster (
        .out_stream_aclk (out_stream_aclk),
        .reset           (reset),
        .advance         (dispatch_c),
        .x               (r_x),
        .y               (r_y),
        .sof             (r_sof),
        .eol             (r_eol),
        .wrap            (r_wrap)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_ENG - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid_c    = (slot_q[rp_q] == DONE);
    assign dispatch_c = enable && (slot_q[dp_q] == IDLE);
    assign retire_c   = valid_c && bus.out_ready;

    // Slot next-state: done capture, in-order retire, round-robin dispatch
    always_comb begin
        slot_d  = slot_q;
        depth_d = depth_q;
        tag_d   = tag_q;
        dp_d    = dp_q;
        rp_d    = rp_q;
        start_d = '0;
        for (int k = 0; k < int'(N_ENG); k++) begin
            if (bus.eng_done[k] && (slot_q[k] == BUSY)) begin
                slot_d[k]  = DONE;
                depth_d[k] = bus.eng_depth[k*DEPTH_W +: DEPTH_W];
            end
        end
        if (retire_c) begin
            slot_d[rp_q] = IDLE;
            rp_d         = ptr_inc(rp_q);
        end
        // Dispatch only sees slots already IDLE, so a slot retired now waits a cycle
        if (dispatch_c) begin
            slot_d[dp_q]     = BUSY;
            tag_d[dp_q].sof  = r_sof;
            tag_d[dp_q].eol  = r_eol;
            tag_d[dp_q].last = r_wrap;
            start_d[dp_q]    = 1'b1;
            dp_d             = ptr_inc(dp_q);
        end
    end

    always_ff @(posedge out_stream_aclk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(N_ENG); k++) begin
                slot_q[k]  <= IDLE;
                depth_q[k] <= '0;
                tag_q[k]   <= '0;
            end
            dp_q    <= '0;
            rp_q    <= '0;
            start_q <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
        end else begin
            slot_q  <= slot_d;
            depth_q <= depth_d;
            tag_q   <= tag_d;
            dp_q    <= dp_d;
            rp_q    <= rp_d;
            start_q <= start_d;
            if (dispatch_c) begin
                ex_q <= r_x;
                ey_q <= r_y;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < int'(N_ENG); k++) begin
            if (slot_q[k] != IDLE) busy = 1'b1;
        end
    end

    assign bus.eng_start = start_q;
    assign bus.eng_x     = ex_q;
    assign bus.eng_y     = ey_q;
    assign bus.out_valid = valid_c;
    assign bus.out_depth = depth_q[rp_q];
    assign bus.out_sof   = tag_q[rp_q].sof;
    assign bus.out_eol   = tag_q[rp_q].eol;
    assign frame_done    = retire_c && tag_q[rp_q].last;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Randomized bench: engine models with variable latency, packer backpressure, queue-based raster reference.
module tb_pixel_scheduler;

    localparam int N    = 4;
    localparam int XS   = 24;
    localparam int YS   = 5;
    localparam int DW   = 10;
    localparam int NPIX = XS * YS;
    localparam int RB   = 32;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic frame_done;
    logic busy;

    pixel_scheduler_if #(.N_ENG(N), .DEPTH_W(DW)) bus ();

    pixel_scheduler #(.N_ENG(N), .X_SIZE(XS), .Y_SIZE(YS), .DEPTH_W(DW)) dut (
        .out_stream_aclk (clk),
        .reset           (rst),
        .enable          (en),
        .bus             (bus),
        .frame_done      (frame_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pixel index, in-flight result queue in dispatch order, engine timers
    int pix, exp_dp, occ, next_id, accepts, starts, obs_fd, obs_eol;
    bit prev_en, acc_prev;
    int rec_x [RB];
    int rec_y [RB];
    int rec_depth [RB];
    bit rec_done [RB];
    int order[$];
    int pend[$];
    int lat_tab[$];
    int eng_cnt [N];
    int eng_id [N];
    bit eng_act [N];
    bit eng_stale [N];
    bit en_cfg;
    int rdy_mode;   // 0 always ready, 1 never ready, 2 random
    int lat_mode;   // 0 fixed, 1 random
    int lat_fixed;

    task automatic model_clear();
        pix = 0; exp_dp = 0; occ = 0; accepts = 0; starts = 0;
        obs_fd = 0; obs_eol = 0;
        prev_en = 1'b0; acc_prev = 1'b0;
        order.delete();
        pend.delete();
        for (int k = 0; k < N; k++) if (eng_act[k]) eng_stale[k] = 1'b1;
    endtask

    task automatic tick();
        logic [N-1:0]    done_v;
        logic [N*DW-1:0] dep_v;
        bit exp_start, exp_valid, rdy, last;
        int id, h, lat;
        @(negedge clk);
        foreach (pend[i]) rec_done[pend[i] % RB] = 1'b1;
        pend.delete();

        exp_start = prev_en && (occ < N);
        check("start_any", 32'(|bus.eng_start), 32'(exp_start));
        if (exp_start) begin
            check("start_eng", 32'(bus.eng_start), 32'(1) << exp_dp);
            check("start_x", 32'(bus.eng_x), 32'(pix % XS));
            check("start_y", 32'(bus.eng_y), 32'(pix / XS));
            id = next_id++;
            rec_x[id % RB]     = pix % XS;
            rec_y[id % RB]     = pix / XS;
            rec_depth[id % RB] = int'($urandom_range(0, (1 << DW) - 1));
            rec_done[id % RB]  = 1'b0;
            order.push_back(id);
            if (lat_tab.size() > 0) lat = lat_tab.pop_front();
            else if (lat_mode == 0)  lat = lat_fixed;
            else                     lat = int'($urandom_range(1, 12));
            eng_act[exp_dp] = 1'b1; eng_stale[exp_dp] = 1'b0;
            eng_id[exp_dp] = id;    eng_cnt[exp_dp] = lat;
            exp_dp = (exp_dp + 1) % N;
            pix = (pix + 1) % NPIX;
            starts++;
        end
        occ = occ - int'(acc_prev) + int'(exp_start);
        check("busy", 32'(busy), 32'(occ > 0));

        exp_valid = (order.size() > 0) && rec_done[order[0] % RB];
        last = 1'b0;
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            h = order[0] % RB;
            last = (rec_x[h] == XS - 1) && (rec_y[h] == YS - 1);
            check("out_depth", 32'(bus.out_depth), 32'(rec_depth[h]));
            check("out_sof", 32'(bus.out_sof), 32'((rec_x[h] == 0) && (rec_y[h] == 0)));
            check("out_eol", 32'(bus.out_eol), 32'(rec_x[h] == XS - 1));
        end

        done_v = '0;
        dep_v  = (N*DW)'({$urandom(), $urandom()});
        for (int k = 0; k < N; k++) begin
            if (eng_act[k]) begin
                eng_cnt[k]--;
                if (eng_cnt[k] == 0) begin
                    done_v[k] = 1'b1;
                    eng_act[k] = 1'b0;
                    if (!eng_stale[k]) begin
                        dep_v[k*DW +: DW] = DW'(rec_depth[eng_id[k] % RB]);
                        pend.push_back(eng_id[k]);
                    end
                end
            end else if ($urandom_range(0, 15) == 0) begin
                done_v[k] = 1'b1;   // spurious pulse on a non-busy slot
            end
        end
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'b0;
            default: rdy = ($urandom_range(0, 2) != 0);
        endcase
        bus.eng_done  = done_v;
        bus.eng_depth = dep_v;
        bus.out_ready = rdy;
        en = en_cfg;
        #1;
        check("frame_done", 32'(frame_done), 32'(exp_valid && rdy && last));
        if (frame_done) obs_fd++;
        if (bus.out_valid && rdy && bus.out_eol) obs_eol++;
        acc_prev = exp_valid && rdy;
        if (acc_prev) begin
            void'(order.pop_front());
            accepts++;
        end
        prev_en = en_cfg && !rst;
    endtask

    task automatic check_reset_outputs();
        check("rst_start", 32'(bus.eng_start), 32'(0));
        check("rst_valid", 32'(bus.out_valid), 32'(0));
        check("rst_depth", 32'(bus.out_depth), 32'(0));
        check("rst_sof", 32'(bus.out_sof), 32'(0));
        check("rst_eol", 32'(bus.out_eol), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
    endtask

    task automatic do_reset(input bit en_after);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_clear();
        repeat (2) tick();
        en_cfg = en_after;
        en = en_after;
        rst = 1'b0;
        prev_en = en_after;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        bit any;
        c = 0;
        forever begin
            any = 1'b0;
            for (int k = 0; k < N; k++) if (eng_act[k]) any = 1'b1;
            if (!any && order.size() == 0 && occ == 0 && !acc_prev) break;
            if (c >= budget) begin
                check("idle_timeout", 32'(c), 32'(budget + 1));
                break;
            end
            tick();
            c++;
        end
    endtask

    task automatic run_until_starts(input int target, input int budget);
        int c;
        c = 0;
        while (starts < target && c < budget) begin
            tick();
            c++;
        end
        if (starts < target) check("start_timeout", 32'(starts), 32'(target));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en_cfg = 1'b0;
        bus.eng_done = '0; bus.eng_depth = '0; bus.out_ready = 1'b0;
        next_id = 0; rdy_mode = 0; lat_mode = 0; lat_fixed = 5;
        for (int k = 0; k < N; k++) begin
            eng_act[k] = 1'b0; eng_stale[k] = 1'b0; eng_cnt[k] = 0; eng_id[k] = 0;
        end
        // Power-up reset, then fixed latency 5 with the packer always ready
        do_reset(1'b1);
        repeat (40) tick();

        // First four pixels with latencies 20,3,3,3: pixel 0 holds up the rest
        en_cfg = 1'b0;
        wait_idle(200);
        lat_tab = '{20, 3, 3, 3};
        lat_mode = 1;
        do_reset(1'b1);
        repeat (40) tick();

        // Packer stalls with every slot DONE, then releases
        rdy_mode = 1;
        repeat (30) tick();
        check("stall_full_occ", 32'(occ), 32'(N));
        rdy_mode = 0;
        repeat (12) tick();

        // Random backpressure, latencies and enable toggling across frames
        rdy_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) en_cfg = !en_cfg;
            tick();
        end

        // Enable dropped after ~100 dispatches; drain; resume at saved position
        en_cfg = 1'b1;
        starts = 0;
        run_until_starts(100, 2000);
        en_cfg = 1'b0;
        wait_idle(300);
        repeat (5) tick();
        check("drained_busy", 32'(busy), 32'(0));
        en_cfg = 1'b1;
        starts = 0;
        run_until_starts(3, 50);

        // Reset with three engines busy; stale done pulses arrive after release
        en_cfg = 1'b0;
        wait_idle(300);
        lat_mode = 0; lat_fixed = 30; rdy_mode = 0;
        do_reset(1'b1);
        run_until_starts(3, 20);
        do_reset(1'b0);
        wait_idle(100);
        repeat (3) tick();
        check("stale_valid", 32'(bus.out_valid), 32'(0));
        check("stale_busy", 32'(busy), 32'(0));
        lat_mode = 1;
        en_cfg = 1'b1;
        starts = 0;
        run_until_starts(2, 20);

        // One clean full frame from reset
        en_cfg = 1'b0;
        wait_idle(300);
        do_reset(1'b1);
        begin
            int c;
            c = 0;
            while (accepts < NPIX && c < NPIX * 20) begin
                if (accepts == NPIX - 1) en_cfg = 1'b0;
                tick();
                c++;
            end
        end
        check("frame_accepts", 32'(accepts), 32'(NPIX));
        check("frame_done_count", 32'(obs_fd), 32'(1));
        check("frame_eol_count", 32'(obs_eol), 32'(YS));
        en_cfg = 1'b1;
        starts = 0;
        run_until_starts(1, 20);
        en_cfg = 1'b0;
        wait_idle(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 Parameter N_ENG, default 4: number of depth_calculator engines served (2..8).
REQ-002 Parameter X_SIZE, default 640: pixels per line.
REQ-003 Parameter Y_SIZE, default 480: lines per frame.
REQ-004 Parameter DEPTH_W, default 10: engine depth result width.
REQ-005 out_stream_aclk  in  1  sole clock; one clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  permits new dispatches; in-flight work always completes.
REQ-008 eng_start  out  N_ENG  one-hot, single-cycle start pulse to engine k.
REQ-009 eng_x  out  10  pixel X for the engine being started; valid only with eng_start.
REQ-010 eng_y  out  9  pixel Y for the engine being started; valid only with eng_start.
REQ-011 eng_done  in  N_ENG  per-engine done pulse.
REQ-012 eng_depth  in  N_ENG*DEPTH_W  per-engine depth; slice k sampled with eng_done[k].
REQ-013 out_valid  out  1  result available to packer.
REQ-014 out_ready  in  1  packer accepts result.
REQ-015 out_depth  out  DEPTH_W  depth of current result.
REQ-016 out_sof  out  1  current result is pixel (0,0).
REQ-017 out_eol  out  1  current result has X = X_SIZE-1.
REQ-018 frame_done  out  1  one-cycle pulse when pixel (X_SIZE-1,Y_SIZE-1) is accepted.
REQ-019 busy  out  1  high while any engine is BUSY or DONE.

Function
REQ-020 Each engine slot SHALL hold state IDLE, BUSY or DONE plus captured depth, sof and eol tags.
REQ-021 Dispatch pointer dp and retire pointer rp SHALL each cycle 0..N_ENG-1 with wrap to 0.
REQ-022 When enable=1 and slot[dp]=IDLE: assert eng_start[dp] for exactly one cycle with current (x,y), store tags, slot[dp]->BUSY, dp increments, raster position advances.
REQ-023 At most one dispatch per cycle; eng_start SHALL be zero in every other cycle.
REQ-024 Raster advance: x increments; at X_SIZE-1, x->0 and y increments; at (X_SIZE-1,Y_SIZE-1), both ->0.
REQ-025 eng_done[k] with slot[k]=BUSY: capture depth slice k, slot[k]->DONE, next cycle.
REQ-026 eng_done[k] with slot[k] not BUSY SHALL be ignored.
REQ-027 out_valid SHALL equal (slot[rp]=DONE); out_depth, out_sof and out_eol SHALL come from slot[rp].
REQ-028 out_valid&&out_ready: slot[rp]->IDLE, rp increments; out_* SHALL remain stable while out_valid&&!out_ready.
REQ-029 A slot retired in cycle t SHALL become dispatchable in cycle t+1 (no same-cycle bypass).
REQ-030 Results SHALL leave in strict raster order regardless of engine completion order.
REQ-031 Engine latency is any value >=1 cycle; start-to-done-capture adds 1 cycle; done-capture to out_valid adds 0 cycles.
REQ-032 enable deasserted mid-frame: dispatching stops, outstanding results drain normally, and dispatch resumes at the saved raster position on re-enable.
REQ-033 frame_done SHALL pulse in the cycle of the accepting handshake for the last pixel.

Reset
REQ-034 When reset is asserted, all slots SHALL go IDLE and dp, rp, x and y SHALL go to 0 immediately.
REQ-035 During reset, eng_start, out_valid, out_depth, out_sof, out_eol, frame_done and busy SHALL be 0.
REQ-036 Reset mid-operation SHALL discard in-flight results; later eng_done pulses from those engines SHALL be ignored per REQ-026.

Structure
REQ-037 Shared package mandel_pkg SHALL hold X_SIZE, Y_SIZE, DEPTH_W and the slot-state enum (IDLE, BUSY, DONE).
REQ-038 One sub-module, raster_counter (x, y, sof, eol, advance input, wrap), SHALL implement REQ-024.

Verification
REQ-039 Engines with fixed latency 5, out_ready=1, enable=1 -> 4 starts in cycles 1-4 at (0,0)..(3,0); first out_valid has out_sof=1.
REQ-040 Latencies 20, 3, 3, 3 for the first four pixels -> outputs in order x=0,1,2,3; out_valid stays low until engine 0 is done.
REQ-041 out_ready=0 for 10 cycles with all slots DONE -> no eng_start, out_depth stable; release -> one retire per cycle.
REQ-042 Full 640x480 frame -> 307200 accepts, out_eol every 640th, one frame_done on the last, next dispatch at (0,0).
REQ-043 enable dropped after 100 dispatches -> no starts, 100 results drain; re-enable -> next start at (100,0).
REQ-044 reset asserted with 3 engines BUSY -> outputs 0 immediately; stale eng_done ignored; first post-reset start at (0,0) on engine 0.
